// File: rtl/seq_udiv8.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional early divide-by-zero exit with err flag: define SEQ_UDIV_DIVZERO_EN.
module seq_udiv8 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  div_q, div_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
`ifdef SEQ_UDIV_DIVZERO_EN
    logic          err_q, err_d;
`endif

    // Shifted partial remainder P' is N+1 bits so the compare works for divisors >= 2^(N-1).
    // Only N bits are stored: after each step P < divisor, so the top bit is always zero.
    logic [N:0]    p_shift;
    logic [N-1:0]  p_diff;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_d     = state_q;
        quo_d       = quo_q;
        div_d       = div_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_UDIV_DIVZERO_EN
        err_d       = err_q;
`endif
        p_shift = {rem_q, quo_q[N-1]};
        p_diff  = p_shift[N-1:0] - div_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    quo_d      = a;
                    div_d      = b;
                    rem_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (p_shift >= {1'b0, div_q}) begin
                    rem_d = p_diff;
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = p_shift[N-1:0];
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
`ifdef SEQ_UDIV_DIVZERO_EN
                    err_d       = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase

`ifdef SEQ_UDIV_DIVZERO_EN
        // First RUN cycle still holds the untouched dividend in quo_q, so r=a comes for free.
        if (state_q == RUN && div_q == '0) begin
            quo_d       = '1;
            rem_d       = quo_q;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            quo_q       <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEQ_UDIV_DIVZERO_EN
            err_q       <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            state_q     <= state_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_UDIV_DIVZERO_EN
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = quo_q;
    assign r         = rem_q;
`ifdef SEQ_UDIV_DIVZERO_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
